// File: rtl/noc_credit_link.sv
// Pipelined, credit-managed NoC link stage with a local re-timing flit buffer.
// Optional NOC_CREDIT_LINK_STATS_EN adds stat_flits / stat_packets counters.
module noc_credit_link #(
  parameter int unsigned FLIT_WIDTH         = 32,
  parameter int unsigned DEST_WIDTH         = 4,
  parameter int unsigned NUM_PIPELINE       = 0,
  parameter int unsigned LINK_BUFFER_DEPTH  = 2,
  parameter int unsigned DOWNSTREAM_CREDITS = 2
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic                  link_err
`ifdef NOC_CREDIT_LINK_STATS_EN
  ,
  output logic [31:0]           stat_flits,
  output logic [31:0]           stat_packets
`endif
);

  localparam int unsigned PL_W  = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(LINK_BUFFER_DEPTH + 1);
  localparam int unsigned PTR_W = (LINK_BUFFER_DEPTH > 1) ? $clog2(LINK_BUFFER_DEPTH) : 1;
  localparam int unsigned CRD_W = $clog2(DOWNSTREAM_CREDITS + 1);

  // Flit payload packed as {data, dest, is_tail}.
  logic [PL_W-1:0]       in_pl;
  logic                  fwd_vld;
  logic [PL_W-1:0]       fwd_pl;
  logic                  crd_tail;

  logic [PL_W-1:0]       mem_q [LINK_BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CRD_W-1:0]      dcred_q, dcred_d;
  logic                  err_q, err_d;

  logic                  send_out_q;
  logic                  credit_out_q;
  logic [FLIT_WIDTH-1:0] data_out_q;
  logic [DEST_WIDTH-1:0] dest_out_q;
  logic                  is_tail_out_q;

  logic                  push, pop, wr_en, overflow, cred_ovf;
  logic                  empty, full;
  logic [PL_W-1:0]       head;

  assign in_pl = {data_in, dest_in, is_tail_in};

  // Forward and credit-return pipes share the same depth; payload flops are valid-gated.
  if (NUM_PIPELINE > 0) begin : g_pipe
    logic [NUM_PIPELINE-1:0] fwd_vld_q;
    logic [PL_W-1:0]         fwd_pl_q [NUM_PIPELINE];
    logic [NUM_PIPELINE-1:0] crd_q;

    always_ff @(posedge clk_noc) begin
      if (!rst_n) begin
        fwd_vld_q <= '0;
        crd_q     <= '0;
      end else begin
        fwd_vld_q[0] <= send_in;
        crd_q[0]     <= send_out_q;
        for (int i = 1; i < int'(NUM_PIPELINE); i++) begin
          fwd_vld_q[i] <= fwd_vld_q[i-1];
          crd_q[i]     <= crd_q[i-1];
        end
      end
    end

    always_ff @(posedge clk_noc) begin
      if (send_in) fwd_pl_q[0] <= in_pl;
      for (int i = 1; i < int'(NUM_PIPELINE); i++) begin
        if (fwd_vld_q[i-1]) fwd_pl_q[i] <= fwd_pl_q[i-1];
      end
    end

    assign fwd_vld  = fwd_vld_q[NUM_PIPELINE-1];
    assign fwd_pl   = fwd_pl_q[NUM_PIPELINE-1];
    assign crd_tail = crd_q[NUM_PIPELINE-1];
  end else begin : g_nopipe
    assign fwd_vld  = send_in;
    assign fwd_pl   = in_pl;
    assign crd_tail = send_out_q;
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LINK_BUFFER_DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  // Pop sees the incoming flit as well, so an empty buffer is bypassed in the same cycle.
  always_comb begin
    push     = fwd_vld;
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(LINK_BUFFER_DEPTH));
    pop      = (!empty || push) && (dcred_q != '0);
    head     = empty ? fwd_pl : mem_q[rd_ptr_q];
    wr_en    = push && (!full || pop);
    overflow = push && full && !pop;
    cred_ovf = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dcred_d  = dcred_q;

    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);

    if (wr_en && !pop)      count_d = CNT_W'(count_q + 1'b1);
    else if (!wr_en && pop) count_d = CNT_W'(count_q - 1'b1);

    if (pop && !credit_in) begin
      dcred_d = CRD_W'(dcred_q - 1'b1);
    end else if (!pop && credit_in) begin
      if (dcred_q == CRD_W'(DOWNSTREAM_CREDITS)) cred_ovf = 1'b1;
      else                                       dcred_d  = CRD_W'(dcred_q + 1'b1);
    end

    err_d = err_q | overflow | cred_ovf;
  end

  always_ff @(posedge clk_noc) begin
    if (wr_en) mem_q[wr_ptr_q] <= fwd_pl;
  end

  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dcred_q       <= CRD_W'(DOWNSTREAM_CREDITS);
      err_q         <= 1'b0;
      send_out_q    <= 1'b0;
      credit_out_q  <= 1'b0;
      data_out_q    <= '0;
      dest_out_q    <= '0;
      is_tail_out_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      dcred_q       <= dcred_d;
      err_q         <= err_d;
      send_out_q    <= pop;
      credit_out_q  <= crd_tail;
      if (pop) begin
        data_out_q    <= head[PL_W-1 -: FLIT_WIDTH];
        dest_out_q    <= head[DEST_WIDTH:1];
        is_tail_out_q <= head[0];
      end
    end
  end

  assign send_out    = send_out_q;
  assign credit_out  = credit_out_q;
  assign data_out    = data_out_q;
  assign dest_out    = dest_out_q;
  assign is_tail_out = is_tail_out_q;
  assign link_err    = err_q;

`ifdef NOC_CREDIT_LINK_STATS_EN
  logic [31:0] stat_flits_q, stat_packets_q;

  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      stat_flits_q   <= '0;
      stat_packets_q <= '0;
    end else if (pop) begin
      stat_flits_q <= stat_flits_q + 32'd1;
      if (head[0]) stat_packets_q <= stat_packets_q + 32'd1;
    end
  end

  assign stat_flits   = stat_flits_q;
  assign stat_packets = stat_packets_q;
`endif

endmodule
